// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: core write port, debug byte source and sender handshake of uart_tx_sched.
interface uart_tx_sched_if;
  logic       core_we;
  logic [7:0] core_data;
  logic       core_full;
  logic       core_ovf;
  logic       dbg_req;
  logic [7:0] dbg_data;
  logic       dbg_gnt;
  logic [7:0] snd_as;
  logic       snd_ready;
  logic       snd_done;
  logic       busy;
  modport master (
    output core_we, core_data, dbg_req, dbg_data, snd_done,
    input  core_full, core_ovf, dbg_gnt, snd_as, snd_ready, busy
  );
  modport slave (
    input  core_we, core_data, dbg_req, dbg_data, snd_done,
    output core_full, core_ovf, dbg_gnt, snd_as, snd_ready, busy
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: buffers core bytes in a FIFO and issues them one at a time to the UART sender.
// Defining UART_TX_SCHED_DBG_EN adds a debug byte source under round-robin arbitration.
module uart_tx_sched #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input logic CLK,
  input logic RST,
  uart_tx_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI} state_e;
  state_e state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic full_q, ovf_q;
  logic [7:0] as_q, as_d;
  logic wr, pop, pend, pick_dbg, go, issue;
  assign issue = state_q == ISSUE;
  assign go = state_q == IDLE && bus.snd_done && pend;
`ifdef UART_TX_SCHED_DBG_EN
  // last_q = 1 means debug was served last, so the core wins the next tie
  logic last_q, last_d;
  assign pend = bus.dbg_req || cnt_q != '0;
  assign pick_dbg = bus.dbg_req && (cnt_q == '0 || !last_q);
  assign last_d = go ? pick_dbg : last_q;
  assign pop = issue && !last_q;
  assign bus.dbg_gnt = issue && last_q;
  always_ff @(posedge CLK) last_q <= RST ? 1'b1 : last_d;
`else
  logic unused_dbg;
  assign unused_dbg = bus.dbg_req;
  assign pend = cnt_q != '0;
  assign pick_dbg = 1'b0;
  assign pop = issue;
  assign bus.dbg_gnt = 1'b0;
`endif
  assign wr = bus.core_we && !full_q;
  assign cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
  assign as_d = go ? (pick_dbg ? bus.dbg_data : mem_q[rptr_q]) : as_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT_LO;
      WAIT_LO: state_d = bus.snd_done ? WAIT_LO : WAIT_HI;
      default: state_d = bus.snd_done ? IDLE : WAIT_HI;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
      as_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_q + AW'(wr);
      rptr_q <= rptr_q + AW'(pop);
      cnt_q <= cnt_d;
      full_q <= cnt_d == (AW+1)'(DEPTH);
      ovf_q <= ovf_q | (bus.core_we & full_q);
      as_q <= as_d;
    end
  end
  always_ff @(posedge CLK) if (wr) mem_q[wptr_q] <= bus.core_data;
  assign bus.snd_as = as_q;
  assign bus.snd_ready = issue;
  assign bus.core_full = full_q;
  assign bus.core_ovf = ovf_q;
  assign bus.busy = state_q != IDLE || cnt_q != '0;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: behavioural sender plus scoreboard around uart_tx_sched.
// Debug-port sequences follow UART_TX_SCHED_DBG_EN.
module tb_uart_tx_sched;
  localparam int DEPTH = 16, BIT = 4, FRAME = 10 * BIT;
  logic CLK = 1'b0, RST = 1'b1;
  uart_tx_sched_if bus();
  uart_tx_sched #(.DEPTH(DEPTH)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  int checks = 0, passes = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // Sender: holds snd_done low for one 10-bit frame after sampling snd_ready
  int scnt = 0, viol = 0, occ = 0;
  logic stall = 1'b0, sb_on = 1'b1, ready_prev = 1'b0, ovf_exp = 1'b0;
  logic [9:0] frame = '1;
  logic [7:0] sent_q[$], exp_q[$];
  logic line_q[$];
  assign bus.snd_done = !stall && scnt == 0;
  always @(posedge CLK) begin
    logic acc, popm;
    ready_prev <= bus.snd_ready;
    if (bus.snd_ready && (!bus.snd_done || ready_prev)) viol <= viol + 1;
    if (scnt > 0) begin
      scnt <= scnt - 1;
      if ((scnt - 1) % BIT == 0) line_q.push_back(frame[(FRAME - scnt) / BIT]);
    end else if (bus.snd_ready && bus.snd_done) begin
      scnt <= FRAME;
      frame <= {1'b1, bus.snd_as, 1'b0};
      sent_q.push_back(bus.snd_as);
    end
    if (RST) begin
      occ <= 0;
      ovf_exp <= 1'b0;
      exp_q.delete();
    end else begin
      acc = bus.core_we && occ != DEPTH;
      popm = bus.snd_ready && bus.snd_done;
      if (bus.core_we && occ == DEPTH) ovf_exp <= 1'b1;
      if (popm && sb_on) begin
        chk("issue_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("issue_order", bus.snd_as, exp_q[0]);
      end
      if (popm && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(bus.core_data);
      occ <= occ + int'(acc) - int'(popm && occ != 0);
    end
  end
  always @(negedge CLK) if (sb_on && !RST) begin
    chk("core_full", bus.core_full, occ == DEPTH);
    chk("core_ovf", bus.core_ovf, ovf_exp);
  end
  task automatic write_byte(input logic [7:0] d);
    bus.core_we = 1'b1;
    bus.core_data = d;
    @(negedge CLK);
    bus.core_we = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (!(bus.busy === 1'b0 && bus.snd_done === 1'b1) && n < 3000) begin @(negedge CLK); n++; end
    chk({name, "_idle"}, bus.busy, 0);
  endtask
  task automatic wait_done(input logic v, input string name);
    int n = 0;
    while (bus.snd_done !== v && n < 4 * FRAME) begin @(negedge CLK); n++; end
    chk({name, "_done"}, bus.snd_done, v);
  endtask
  typedef struct { logic [7:0] data; logic [9:0] line; } vec_t;
  vec_t vt[5];
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, gn, rate;
    logic rdy;
    logic [9:0] got;
    vt[0] = '{8'hA5, 10'h34A};
    vt[1] = '{8'h00, 10'h200};
    vt[2] = '{8'hFF, 10'h3FE};
    vt[3] = '{8'h3C, 10'h278};
    vt[4] = '{8'h81, 10'h302};
    bus.core_we = 1'b0;
    bus.core_data = '0;
    bus.dbg_req = 1'b0;
    bus.dbg_data = '0;
    repeat (3) @(negedge CLK);
    chk("rst_snd_ready", bus.snd_ready, 0);
    chk("rst_snd_as", bus.snd_as, 0);
    chk("rst_dbg_gnt", bus.dbg_gnt, 0);
    chk("rst_core_full", bus.core_full, 0);
    chk("rst_core_ovf", bus.core_ovf, 0);
    chk("rst_busy", bus.busy, 0);
    RST = 1'b0;
    @(negedge CLK);
    for (int v = 0; v < 5; v++) begin
      wait_idle("vec_pre");
      line_q.delete();
      write_byte(vt[v].data);
      chk("vec_ready_c1", bus.snd_ready, 0);
      chk("vec_busy_c1", bus.busy, 1);
      @(negedge CLK);
      chk("vec_ready_c2", bus.snd_ready, 1);
      chk("vec_snd_as", bus.snd_as, vt[v].data);
      wait_idle("vec_frame");
      chk("vec_line_len", line_q.size(), 10);
      got = '0;
      for (int b = 0; b < 10 && b < line_q.size(); b++) got[b] = line_q[b];
      chk("vec_line", got, vt[v].line);
    end
    wait_idle("burst_pre");
    sent_q.delete();
    for (int i = 0; i < 3; i++) begin
      bus.core_we = 1'b1;
      bus.core_data = 8'(i + 1);
      @(negedge CLK);
    end
    bus.core_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_done(1'b0, "burst_lo");
      wait_done(1'b1, "burst_hi");
      if (k < 2) begin
        n = 0;
        while (!bus.snd_ready && n < 10) begin @(negedge CLK); n++; end
        chk("burst_gap", n, 2);
      end else begin
        chk("burst_busy_hold", bus.busy, 1);
        @(negedge CLK);
        chk("burst_busy_fall", bus.busy, 0);
      end
    end
    chk("burst_count", sent_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("burst_byte", sent_q[i], 8'(i + 1));
    wait_idle("full_pre");
    sent_q.delete();
    stall = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.core_we = 1'b1;
      bus.core_data = 8'(8'h20 + i);
      @(negedge CLK);
      if (i == 14) chk("full_at_15", bus.core_full, 0);
      if (i == 15) chk("full_at_16", bus.core_full, 1);
    end
    bus.core_we = 1'b0;
    chk("ovf_after_17", bus.core_ovf, 1);
    stall = 1'b0;
    wait_idle("full_drain");
    chk("full_count", sent_q.size(), 16);
    for (int i = 0; i < 16; i++) chk("full_byte", sent_q[i], 8'(8'h20 + i));
    chk("ovf_sticky", bus.core_ovf, 1);
    sent_q.delete();
    for (int i = 0; i < 4; i++) write_byte(8'(8'h40 + i));
    n = 0;
    while (scnt != FRAME - 4 * BIT - 1 && n < 4 * FRAME) begin @(negedge CLK); n++; end
    chk("mid_bit4_reached", scnt, FRAME - 4 * BIT - 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_full", bus.core_full, 0);
    chk("mid_rst_ovf", bus.core_ovf, 0);
    n = 0;
    rdy = 1'b0;
    while (!bus.snd_done && n < 2 * FRAME) begin rdy |= bus.snd_ready; @(negedge CLK); n++; end
    chk("mid_frame_ends", bus.snd_done, 1);
    repeat (5) begin rdy |= bus.snd_ready; @(negedge CLK); end
    chk("mid_no_ready", rdy, 0);
    chk("mid_empty", bus.busy, 0);
    write_byte(8'h77);
    wait_idle("mid_after");
    chk("mid_count", sent_q.size(), 2);
    chk("mid_inflight", sent_q[0], 8'h40);
    chk("mid_new", sent_q[1], 8'h77);
    for (int i = 0; i < 1500; i++) begin
      rate = ((i / 250) % 2 == 1) ? 3 : 60;
      bus.core_we = $urandom_range(0, 99) < rate;
      bus.core_data = 8'($urandom);
      if (stall ? ($urandom_range(0, 19) == 0) : (scnt > 0 && $urandom_range(0, 29) == 0)) stall = ~stall;
      @(negedge CLK);
    end
    bus.core_we = 1'b0;
    stall = 1'b0;
    wait_idle("rand_drain");
    chk("rand_all_issued", exp_q.size(), 0);
`ifdef UART_TX_SCHED_DBG_EN
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    sb_on = 1'b0;
    stall = 1'b1;
    write_byte(8'h10);
    write_byte(8'h11);
    sent_q.delete();
    bus.dbg_data = 8'hD0;
    bus.dbg_req = 1'b1;
    stall = 1'b0;
    n = 0;
    gn = 0;
    while (!(sent_q.size() == 3 && bus.busy == 1'b0 && bus.snd_done) && n < 1000) begin
      @(negedge CLK);
      n++;
      if (bus.dbg_gnt) begin
        gn++;
        chk("arb_gnt_ready", bus.snd_ready, 1);
        chk("arb_gnt_as", bus.snd_as, 8'hD0);
        bus.dbg_req = 1'b0;
      end
    end
    chk("arb_gnt_count", gn, 1);
    chk("arb_count", sent_q.size(), 3);
    chk("arb_first", sent_q[0], 8'h10);
    chk("arb_second", sent_q[1], 8'hD0);
    chk("arb_third", sent_q[2], 8'h11);
`else
    sent_q.delete();
    bus.dbg_data = 8'hAA;
    bus.dbg_req = 1'b1;
    write_byte(8'h55);
    n = 0;
    gn = 0;
    while (!(bus.busy == 1'b0 && bus.snd_done) && n < 1000) begin
      gn += int'(bus.dbg_gnt);
      @(negedge CLK);
      n++;
    end
    repeat (4 * FRAME) begin gn += int'(bus.dbg_gnt); @(negedge CLK); end
    bus.dbg_req = 1'b0;
    chk("off_count", sent_q.size(), 1);
    chk("off_byte", sent_q[0], 8'h55);
    chk("off_no_gnt", gn, 0);
`endif
    chk("protocol", viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that sits between the core's output instruction path and the byte-serial UART `sender`. It buffers bytes written by the core in a FIFO and optionally merges a second, debug byte source under round-robin arbitration. It issues exactly one byte at a time to the sender using the sender's `ready`/`done` handshake, and never overlaps frames.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `AW`, `$clog2(DEPTH)`: FIFO pointer width; the occupancy counter is AW+1 bits.

- `CLK` in 1: system clock.
- `RST` in 1: synchronous reset, active-high.
- `core_we` in 1: core write strobe; one byte per cycle.
- `core_data` in 8: byte to enqueue.
- `core_full` out 1: registered; 1 when occupancy == DEPTH.
- `core_ovf` out 1: sticky; set when `core_we` is asserted while `core_full` is 1; cleared only by `RST`.
- `dbg_req` in 1: debug source has a byte; held until granted.
- `dbg_data` in 8: debug byte; stable while `dbg_req` is 1.
- `dbg_gnt` out 1: one-cycle pulse; the debug byte was issued to the sender.
- `snd_as` out 8: byte to the sender; registered.
- `snd_ready` out 1: start pulse to the sender; exactly one cycle wide.
- `snd_done` in 1: sender idle flag; 1 = idle.
- `busy` out 1: 1 when state ≠ IDLE or the FIFO is non-empty.

## Operation
- FIFO:
  - Write when `core_we && !core_full`. Pop when a core byte is issued.
  - A write and a pop in the same cycle leave occupancy unchanged.
  - A write to a full FIFO is dropped and sets `core_ovf`; a pop in that same cycle does not make that write succeed.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - **IDLE**: when `snd_done` is 1 and a source is pending, select the source, load `snd_as`, assert `snd_ready` next cycle, go to ISSUE. Otherwise stay.
  - **ISSUE**: `snd_ready` is 1 for this single cycle. Pop the FIFO if the core was selected; pulse `dbg_gnt` if debug was selected. Go to WAIT_LO.
  - **WAIT_LO**: wait for `snd_done` to be 0. This confirms the sender accepted the byte. Then go to WAIT_HI.
  - **WAIT_HI**: wait for `snd_done` to be 1, i.e. the stop bit is complete. Then go to IDLE.
- Arbitration (debug compiled in):
  - Round-robin between the core FIFO and debug.
  - A `last` bit records the last-served source; on a tie the other source wins.
  - `last` resets to debug, so the core wins the first tie.
- The selected byte is captured into `snd_as` at the IDLE→ISSUE transition. `snd_as` holds that value until the next issue.
- Reset mid-frame:
  - Go to IDLE, empty the FIFO, clear `core_ovf`.
  - The sender has no reset input. IDLE's `snd_done` check therefore blocks a new issue until the in-flight frame finishes.

## Timing
- Reset values:
  - `snd_ready` = 0, `snd_as` = 8'h00, `dbg_gnt` = 0.
  - `core_full` = 0, `core_ovf` = 0, `busy` = 0.
  - State = IDLE, occupancy = 0, `last` = debug.
- Latency, sender idle and FIFO empty:
  - `core_we` in cycle 0 makes occupancy 1 in cycle 1.
  - IDLE decides in cycle 1.
  - `snd_ready` = 1 in cycle 2.
- The sender drops `snd_done` in the cycle after it samples `snd_ready`. One frame is 10 bit periods of 2585 `CLK` each, 25850 cycles per byte.
- Back-to-back bytes: the next `snd_ready` follows 2 cycles after `snd_done` rises (IDLE decision, then ISSUE).
- `snd_ready` is never asserted while `snd_done` is 0, or outside ISSUE.

## Configuration
- `UART_TX_SCHED_DBG_EN` defined:
  - The debug port and the round-robin arbiter are built.
- `UART_TX_SCHED_DBG_EN` undefined:
  - The `dbg_*` inputs are ignored and `dbg_gnt` is tied 0.
  - The core FIFO is the only source; there is no `last` register.
  - All other behaviour is identical.

## Test plan
- Single byte: write 8'hA5 with the sender idle → `snd_ready` pulse in cycle 2 with `snd_as` = 8'hA5; serial line shows 0,1,0,1,0,0,1,0,1,1 (LSB first), 2585 cycles per bit.
- Burst: write 8'h01, 8'h02, 8'h03 on consecutive cycles → three frames in order with no overlap; each `snd_ready` comes 2 cycles after `snd_done` rises; `busy` falls after the third stop bit.
- Full/overflow (DEPTH = 16, sender stalled): 17 writes → `core_full` = 1 after the 16th, 17th write dropped, `core_ovf` = 1; 16 frames then sent in order.
- Arbitration (debug enabled): FIFO holds 8'h10, 8'h11 and `dbg_req` is held with 8'hD0 → issue order 8'h10, 8'hD0, 8'h11; `dbg_gnt` pulses exactly once, in the ISSUE cycle of 8'hD0.
- Reset mid-frame: `RST` pulsed during bit 4 of a frame while 3 bytes are queued → FIFO empty and no `snd_ready` until `snd_done` returns to 1; a write after that is sent normally.
- Macro off: drive `dbg_req` = 1 and write 8'h55 → only 8'h55 is sent; `dbg_gnt` stays 0.
